// File: rtl/break_min_select.sv
// break_min_select: accumulates saturating per-candidate break counts over a
// clause beat stream, then scans them one candidate per cycle to pick the
// variable to flip (minimum break, lowest index on ties, or a random
// candidate on a noise step when no zero-break candidate exists).
module break_min_select #(
    parameter int NSAT  = 3,
    parameter int CNT_W = 8,
    parameter int IDX_W = $clog2(NSAT)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               break_valid_i,
    input  logic [NSAT-1:0]    break_i,
    input  logic               last_i,
    input  logic               noise_i,
    input  logic [IDX_W-1:0]   rand_idx_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [IDX_W-1:0]   sel_idx_o,
    output logic [CNT_W-1:0]   min_break_o,
    output logic               zero_break_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [CNT_W-1:0]   r_cnt [NSAT];
    logic [IDX_W-1:0]   r_cmp_idx;
    logic [CNT_W-1:0]   r_min_val;
    logic [IDX_W-1:0]   r_min_idx;
    logic               r_noise;
    logic [IDX_W-1:0]   r_rand_idx;

    logic [IDX_W-1:0]   r_sel_idx;
    logic [CNT_W-1:0]   r_min_break;
    logic               r_zero_break;

    logic               w_start;
    logic               w_beat;
    logic               w_last_beat;
    logic               w_last_cmp;
    logic [CNT_W-1:0]   w_cur_cnt;
    logic               w_take;
    logic [CNT_W-1:0]   w_min_val;
    logic [IDX_W-1:0]   w_min_idx;
    logic [IDX_W-1:0]   w_rand_sel;
    logic [CNT_W-1:0]   w_rand_cnt;
    logic [IDX_W-1:0]   w_res_sel;
    logic [CNT_W-1:0]   w_res_min;
    logic               w_res_zero;

    assign w_start     = (r_state == S_IDLE) && start_i;
    assign w_beat      = (r_state == S_ACCUM) && break_valid_i;
    assign w_last_beat = w_beat && last_i;
    assign w_last_cmp  = (r_cmp_idx == IDX_W'(NSAT - 1));

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_next_state = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (break_valid_i && last_i) begin
                    w_next_state = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (w_last_cmp) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Saturating break counters: cleared on start, bumped on each accepted beat
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned k = 0; k < NSAT; k++) begin
                r_cnt[k] <= '0;
            end
        end else if (w_start) begin
            for (int unsigned k = 0; k < NSAT; k++) begin
                r_cnt[k] <= '0;
            end
        end else if (w_beat) begin
            for (int unsigned k = 0; k < NSAT; k++) begin
                if (break_i[k] && (r_cnt[k] != '1)) begin
                    r_cnt[k] <= r_cnt[k] + 1'b1;
                end
            end
        end
    end

    // Noise request and random index captured with the last beat only
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_noise    <= 1'b0;
            r_rand_idx <= '0;
        end else if (w_last_beat) begin
            r_noise    <= noise_i;
            r_rand_idx <= rand_idx_i;
        end
    end

    // Counter currently under comparison and the running-minimum update
    always_comb begin
        w_cur_cnt = '0;
        for (int unsigned k = 0; k < NSAT; k++) begin
            if (r_cmp_idx == IDX_W'(k)) begin
                w_cur_cnt = r_cnt[k];
            end
        end
        // Candidate 0 seeds the running min; later ones must be strictly lower.
        w_take    = (r_cmp_idx == '0) || (w_cur_cnt < r_min_val);
        w_min_val = w_take ? w_cur_cnt : r_min_val;
        w_min_idx = w_take ? r_cmp_idx : r_min_idx;
    end

    // Noise-step candidate: out-of-range random indices fold to candidate 0
    always_comb begin
        w_rand_sel = '0;
        if ({1'b0, r_rand_idx} < (IDX_W + 1)'(NSAT)) begin
            w_rand_sel = r_rand_idx;
        end
        w_rand_cnt = '0;
        for (int unsigned k = 0; k < NSAT; k++) begin
            if (w_rand_sel == IDX_W'(k)) begin
                w_rand_cnt = r_cnt[k];
            end
        end
    end

    // Final selection, evaluated on the last compare cycle
    always_comb begin
        w_res_sel  = w_min_idx;
        w_res_min  = w_min_val;
        w_res_zero = 1'b0;
        if (w_min_val == '0) begin
            w_res_zero = 1'b1;
        end else if (r_noise) begin
            w_res_sel = w_rand_sel;
            w_res_min = w_rand_cnt;
        end
    end

    // Compare index and running minimum registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cmp_idx <= '0;
            r_min_val <= '0;
            r_min_idx <= '0;
        end else if (w_last_beat) begin
            r_cmp_idx <= '0;
        end else if (r_state == S_COMPARE) begin
            r_min_val <= w_min_val;
            r_min_idx <= w_min_idx;
            if (!w_last_cmp) begin
                r_cmp_idx <= r_cmp_idx + 1'b1;
            end
        end
    end

    // Result registers, loaded when the scan completes and held until the next one
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sel_idx    <= '0;
            r_min_break  <= '0;
            r_zero_break <= 1'b0;
        end else if ((r_state == S_COMPARE) && w_last_cmp) begin
            r_sel_idx    <= w_res_sel;
            r_min_break  <= w_res_min;
            r_zero_break <= w_res_zero;
        end
    end

    assign busy_o       = (r_state != S_IDLE);
    assign done_o       = (r_state == S_DONE);
    assign sel_idx_o    = r_sel_idx;
    assign min_break_o  = r_min_break;
    assign zero_break_o = r_zero_break;

endmodule

// File: tb/tb_break_min_select.sv
// Scoreboard bench for break_min_select: stimulus pushes expected results
// computed from a count-and-pick reference model; a negedge monitor pops
// and compares whenever done_o is presented.
module tb_break_min_select;

    localparam int NSAT  = 3;
    localparam int CNT_W = 4;
    localparam int IDX_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst_i;
    logic               start_i;
    logic               break_valid_i;
    logic [NSAT-1:0]    break_i;
    logic               last_i;
    logic               noise_i;
    logic [IDX_W-1:0]   rand_idx_i;
    logic               busy_o;
    logic               done_o;
    logic [IDX_W-1:0]   sel_idx_o;
    logic [CNT_W-1:0]   min_break_o;
    logic               zero_break_o;

    typedef struct {
        int sel;
        int minb;
        int zero;
        int edge_no;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   edge_n    = 0;
    int   done_seen = 0;

    always #5 clk = ~clk;

    break_min_select #(
        .NSAT (NSAT),
        .CNT_W(CNT_W),
        .IDX_W(IDX_W)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .break_valid_i(break_valid_i),
        .break_i      (break_i),
        .last_i       (last_i),
        .noise_i      (noise_i),
        .rand_idx_i   (rand_idx_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .sel_idx_o    (sel_idx_o),
        .min_break_o  (min_break_o),
        .zero_break_o (zero_break_o)
    );

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: count breaks per candidate with clamping, then pick.
    function automatic exp_t model(input logic [NSAT-1:0] bq[$], input logic nz, input int rnd);
        exp_t r;
        int   cnt [NSAT];
        int   minv;
        int   mi;
        int   ri;
        for (int k = 0; k < NSAT; k++) cnt[k] = 0;
        for (int i = 0; i < bq.size(); i++) begin
            for (int k = 0; k < NSAT; k++) begin
                cnt[k] = cnt[k] + int'(bq[i][k]);
                if (cnt[k] > CMAX) cnt[k] = CMAX;
            end
        end
        minv = cnt[0];
        for (int k = 1; k < NSAT; k++) if (cnt[k] < minv) minv = cnt[k];
        mi = -1;
        for (int k = NSAT - 1; k >= 0; k--) if (cnt[k] == minv) mi = k;
        r.edge_no = 0;
        if (minv == 0) begin
            r.sel = mi; r.minb = 0; r.zero = 1;
        end else if (nz) begin
            ri = (rnd < NSAT) ? rnd : 0;
            r.sel = ri; r.minb = cnt[ri]; r.zero = 0;
        end else begin
            r.sel = mi; r.minb = minv; r.zero = 0;
        end
        return r;
    endfunction

    // Monitor: compare every presented result against the scoreboard head
    always @(negedge clk) begin
        if (!rst_i && done_o) begin
            done_seen++;
            if (sb.size() == 0) begin
                check("unexpected_done", int'(done_o), 0);
            end else begin
                mon_e = sb.pop_front();
                check("sel_idx", int'(sel_idx_o), mon_e.sel);
                check("min_break", int'(min_break_o), mon_e.minb);
                check("zero_break", int'(zero_break_o), mon_e.zero);
                check("done_edge", edge_n, mon_e.edge_no);
            end
        end
    end

    task automatic drive_idle_garbage();
        break_valid_i = 1'b0;
        break_i       = NSAT'($urandom);
        last_i        = 1'($urandom);
        noise_i       = 1'($urandom);
        rand_idx_i    = IDX_W'($urandom);
    endtask

    task automatic run_decision(input logic [NSAT-1:0] bq[$], input logic nz, input int rnd,
                                input int gaps);
        exp_t e;
        int   t;
        @(negedge clk);
        start_i       = 1'b1;
        break_valid_i = 1'($urandom);
        last_i        = 1'($urandom);
        @(negedge clk);
        start_i = 1'b0;
        check("busy_after_start", int'(busy_o), 1);
        for (int i = 0; i < bq.size(); i++) begin
            repeat ($urandom_range(0, gaps)) begin
                drive_idle_garbage();
                @(negedge clk);
            end
            break_valid_i = 1'b1;
            break_i       = bq[i];
            if (i == bq.size() - 1) begin
                last_i     = 1'b1;
                noise_i    = nz;
                rand_idx_i = IDX_W'(rnd);
                e          = model(bq, nz, rnd);
                e.edge_no  = edge_n + 1 + NSAT;
                sb.push_back(e);
            end else begin
                last_i     = 1'b0;
                noise_i    = 1'($urandom);
                rand_idx_i = IDX_W'($urandom);
            end
            @(negedge clk);
        end
        break_valid_i = 1'b0;
        last_i        = 1'b0;
        t = 0;
        while (sb.size() != 0 && t < NSAT + 4) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("done_timeout_pending", sb.size(), 0);
        sb.delete();
        @(negedge clk);
        check("busy_after_done", int'(busy_o), 0);
        check("done_single_cycle", int'(done_o), 0);
        check("hold_sel", int'(sel_idx_o), e.sel);
        check("hold_min", int'(min_break_o), e.minb);
    endtask

    logic [NSAT-1:0] q[$];
    exp_t            ex;
    int              d0;

    initial begin
        rst_i = 1'b1;
        start_i = 1'b0;
        break_valid_i = 1'b0;
        break_i = '0;
        last_i = 1'b0;
        noise_i = 1'b0;
        rand_idx_i = '0;
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        check("rst_busy", int'(busy_o), 0);
        check("rst_done", int'(done_o), 0);
        check("rst_sel", int'(sel_idx_o), 0);
        check("rst_min", int'(min_break_o), 0);
        check("rst_zero", int'(zero_break_o), 0);

        // Counts 2,1,1 -> candidate 1 wins the tie
        q = '{3'b011, 3'b001, 3'b100};
        run_decision(q, 1'b0, 0, 0);
        // Zero-break candidate beats a noise request
        q = '{3'b101};
        run_decision(q, 1'b1, 2, 0);
        // Noise step picks the random candidate, out-of-range folds to 0
        q = '{3'b111};
        run_decision(q, 1'b1, 2, 0);
        run_decision(q, 1'b1, 3, 0);
        // Saturation: all counters reach 15, lowest index wins
        q.delete();
        repeat (20) q.push_back(3'b111);
        q.push_back(3'b011);
        run_decision(q, 1'b0, 0, 1);

        // Asynchronous reset in the middle of accumulation
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        break_valid_i = 1'b1;
        break_i = 3'b111;
        last_i = 1'b0;
        @(negedge clk);
        break_i = 3'b010;
        @(negedge clk);
        break_valid_i = 1'b0;
        #2;
        rst_i = 1'b1;
        #1;
        check("midrst_busy", int'(busy_o), 0);
        check("midrst_done", int'(done_o), 0);
        check("midrst_sel", int'(sel_idx_o), 0);
        check("midrst_min", int'(min_break_o), 0);
        check("midrst_zero", int'(zero_break_o), 0);
        @(negedge clk);
        rst_i = 1'b0;
        d0 = done_seen;
        repeat (NSAT + 4) @(negedge clk);
        check("no_done_after_reset", done_seen - d0, 0);
        q = '{3'b110};
        run_decision(q, 1'b0, 0, 0);

        // Inputs outside their accepting state must have no effect
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        break_valid_i = 1'b1;
        break_i = 3'b011;
        last_i = 1'b0;
        @(negedge clk);
        break_i = 3'b110;
        last_i = 1'b1;
        noise_i = 1'b0;
        rand_idx_i = '0;
        q = '{3'b011, 3'b110};
        ex = model(q, 1'b0, 0);
        ex.edge_no = edge_n + 1 + NSAT;
        sb.push_back(ex);
        d0 = done_seen;
        @(negedge clk);
        start_i = 1'b1;
        break_i = 3'b111;
        noise_i = 1'b1;
        rand_idx_i = 2'd2;
        repeat (NSAT + 1) @(negedge clk);
        start_i = 1'b0;
        repeat (4) @(negedge clk);
        break_valid_i = 1'b0;
        last_i = 1'b0;
        check("ignored_one_done", done_seen - d0, 1);
        check("ignored_busy", int'(busy_o), 0);
        check("ignored_hold_sel", int'(sel_idx_o), ex.sel);
        check("ignored_hold_min", int'(min_break_o), ex.minb);
        check("ignored_hold_zero", int'(zero_break_o), ex.zero);
        check("ignored_sb_empty", sb.size(), 0);
        sb.delete();

        // Randomized decisions
        for (int n = 0; n < 30; n++) begin
            int nb;
            q.delete();
            nb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(15, 22)) : int'($urandom_range(1, 6));
            for (int i = 0; i < nb; i++) begin
                if ($urandom_range(0, 1) == 1) q.push_back(NSAT'($urandom));
                else q.push_back(NSAT'($urandom | $urandom));
            end
            run_decision(q, 1'($urandom), int'($urandom_range(0, 3)), 2);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1);
    end

endmodule
